// File: rtl/seq_game_ctrl_if.sv
// Handshake and data bundle between the game controller, user keypad, sequence
// memory and sequence counter. Slave is the controller's view.
interface seq_game_ctrl_if #(
  parameter int SIZE = 4
);
  logic            enter;
  logic            key_valid;
  logic [SIZE-1:0] key;
  logic [SIZE-1:0] seq_val;
  logic            end_FPGA;
  logic            R_FPGA;
  logic            E_FPGA;
  logic [SIZE-1:0] round;
  logic [SIZE-1:0] user_idx;
  logic            show;
  logic            win;
  logic            lose;
  logic [2:0]      state;

  modport slave (
    input  enter, key_valid, key, seq_val, end_FPGA,
    output R_FPGA, E_FPGA, round, user_idx, show, win, lose, state
  );

  modport master (
    output enter, key_valid, key, seq_val, end_FPGA,
    input  R_FPGA, E_FPGA, round, user_idx, show, win, lose, state
  );
endinterface

// File: rtl/seq_game_ctrl.sv
// Memory-game sequencer: plays a growing sequence, then checks user key entry.
// Optional macro TIMEOUT_EN adds a user inactivity timeout of TIMEOUT_CYC cycles.
module seq_game_ctrl #(
  parameter int SIZE        = 4,
  parameter int MAX_ROUND   = 15,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic           CLKHZ,
  input logic           R,
  seq_game_ctrl_if.slave bus
);

  localparam logic [2:0] S_INIT      = 3'd0;
  localparam logic [2:0] S_SETUP     = 3'd1;
  localparam logic [2:0] S_PLAY_FPGA = 3'd2;
  localparam logic [2:0] S_PLAY_USER = 3'd3;
  localparam logic [2:0] S_CHECK     = 3'd4;
  localparam logic [2:0] S_NEXT_RND  = 3'd5;
  localparam logic [2:0] S_RESULT    = 3'd6;

  localparam logic [SIZE-1:0] MAX_R = SIZE'(MAX_ROUND);

  // round and user_idx rely on MAX_ROUND fitting in SIZE bits to never wrap
  if (MAX_ROUND < 0 || MAX_ROUND > (2**SIZE) - 1) begin : g_bad_max_round
    $error("seq_game_ctrl: MAX_ROUND does not fit in SIZE bits");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("seq_game_ctrl: TIMEOUT_CYC must be at least 1");
  end

  logic [2:0]      state_q;
  logic [SIZE-1:0] round_q;
  logic [SIZE-1:0] idx_q;
  logic [SIZE-1:0] key_q;
  logic            win_q;
  logic            lose_q;
  logic            to_hit;

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  // Held at zero outside PLAY_USER, so it starts from zero on every entry
  always_ff @(posedge CLKHZ) begin
    if (R) begin
      to_cnt <= '0;
    end else if (state_q != S_PLAY_USER || bus.key_valid) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge CLKHZ) begin
    if (R) begin
      state_q <= S_INIT;
      round_q <= '0;
      idx_q   <= '0;
      key_q   <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          if (bus.enter) state_q <= S_SETUP;
        end
        S_SETUP: begin
          round_q <= '0;
          idx_q   <= '0;
          state_q <= S_PLAY_FPGA;
        end
        S_PLAY_FPGA: begin
          if (bus.end_FPGA) begin
            idx_q   <= '0;
            state_q <= S_PLAY_USER;
          end
        end
        S_PLAY_USER: begin
          if (bus.key_valid) begin
            key_q   <= bus.key;
            state_q <= S_CHECK;
          end else if (to_hit) begin
            lose_q  <= 1'b1;
            state_q <= S_RESULT;
          end
        end
        S_CHECK: begin
          if (key_q != bus.seq_val) begin
            lose_q  <= 1'b1;
            state_q <= S_RESULT;
          end else if (idx_q == round_q) begin
            state_q <= S_NEXT_RND;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= S_PLAY_USER;
          end
        end
        S_NEXT_RND: begin
          if (round_q == MAX_R) begin
            win_q   <= 1'b1;
            state_q <= S_RESULT;
          end else begin
            round_q <= round_q + 1'b1;
            state_q <= S_PLAY_FPGA;
          end
        end
        S_RESULT: begin
          if (bus.enter) begin
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            round_q <= '0;
            idx_q   <= '0;
            state_q <= S_INIT;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  // Counter clear pulses once in SETUP and once per non-final NEXT_RND
  assign bus.R_FPGA   = (state_q == S_SETUP) ||
                        (state_q == S_NEXT_RND && round_q != MAX_R);
  assign bus.E_FPGA   = (state_q == S_PLAY_FPGA);
  assign bus.show     = (state_q == S_PLAY_FPGA);
  assign bus.round    = round_q;
  assign bus.user_idx = idx_q;
  assign bus.win      = win_q;
  assign bus.lose     = lose_q;
  assign bus.state    = state_q;

endmodule
